// File: rtl/complex_div.sv
// Sequential packed complex divider: out = in1 / in2 using two parallel restoring dividers.
// Optional macro CDIV_ROUND_EN selects round-half-away-from-zero instead of truncation.
module complex_div #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in1,
  input  logic [2*W-1:0] in2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] out,
  output logic           div_zero
);

  localparam int NW = 2*W + 1;
  localparam int CW = $clog2(NW + 1);

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

  state_t          state;
  logic [2*W-1:0]  op1, op2;
  logic [NW-1:0]   nsh_r, nsh_i;
  logic [NW-1:0]   rem_r, rem_i;
  logic [2*W-1:0]  q_r, q_i;
  logic [2*W-1:0]  den;
  logic            sgn_r, sgn_i, zero;
  logic [CW-1:0]   cnt;

  // Components sign-extended to numerator width so products and sums wrap correctly.
  logic signed [NW-1:0] ax, bx, cx, dx, nr, ni;
  logic [2*W-1:0]       cw, dw, den_n;
  logic [NW-1:0]        nr_abs, ni_abs;

  assign ax     = {{(W+1){op1[2*W-1]}}, op1[2*W-1:W]};
  assign bx     = {{(W+1){op1[W-1]}},   op1[W-1:0]};
  assign cx     = {{(W+1){op2[2*W-1]}}, op2[2*W-1:W]};
  assign dx     = {{(W+1){op2[W-1]}},   op2[W-1:0]};
  assign nr     = ax*cx + bx*dx;
  assign ni     = bx*cx - ax*dx;
  assign nr_abs = nr[NW-1] ? -nr : nr;
  assign ni_abs = ni[NW-1] ? -ni : ni;
  assign cw     = {{W{op2[2*W-1]}}, op2[2*W-1:W]};
  assign dw     = {{W{op2[W-1]}},   op2[W-1:0]};
  assign den_n  = cw*cw + dw*dw;

  logic [NW:0]    trial_r, trial_i;
  logic           ge_r, ge_i;
  logic [NW-1:0]  rem_next_r, rem_next_i;

  assign trial_r    = {rem_r, nsh_r[NW-1]};
  assign trial_i    = {rem_i, nsh_i[NW-1]};
  assign ge_r       = trial_r >= {2'b00, den};
  assign ge_i       = trial_i >= {2'b00, den};
  assign rem_next_r = NW'(ge_r ? trial_r - {2'b00, den} : trial_r);
  assign rem_next_i = NW'(ge_i ? trial_i - {2'b00, den} : trial_i);

  logic [2*W-1:0] mag_r, mag_i, fin_r, fin_i;

`ifdef CDIV_ROUND_EN
  assign mag_r = q_r + {{(2*W-1){1'b0}}, ({rem_r, 1'b0} >= {2'b00, den})};
  assign mag_i = q_i + {{(2*W-1){1'b0}}, ({rem_i, 1'b0} >= {2'b00, den})};
`else
  assign mag_r = q_r;
  assign mag_i = q_i;
`endif

  assign fin_r = sgn_r ? -mag_r : mag_r;
  assign fin_i = sgn_i ? -mag_i : mag_i;

  // Control FSM and datapath registers; a zero divisor still runs the full step count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      div_zero  <= 1'b0;
      cnt       <= '0;
      op1       <= '0;
      op2       <= '0;
      nsh_r     <= '0;
      nsh_i     <= '0;
      rem_r     <= '0;
      rem_i     <= '0;
      q_r       <= '0;
      q_i       <= '0;
      den       <= '0;
      sgn_r     <= 1'b0;
      sgn_i     <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op1      <= in1;
            op2      <= in2;
            in_ready <= 1'b0;
            div_zero <= 1'b0;
            state    <= PREP;
          end
        end
        PREP: begin
          nsh_r <= nr_abs;
          nsh_i <= ni_abs;
          sgn_r <= nr[NW-1];
          sgn_i <= ni[NW-1];
          den   <= den_n;
          zero  <= (den_n == '0);
          rem_r <= '0;
          rem_i <= '0;
          q_r   <= '0;
          q_i   <= '0;
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          nsh_r <= {nsh_r[NW-2:0], 1'b0};
          nsh_i <= {nsh_i[NW-2:0], 1'b0};
          rem_r <= rem_next_r;
          rem_i <= rem_next_i;
          q_r   <= {q_r[2*W-2:0], ge_r};
          q_i   <= {q_i[2*W-2:0], ge_i};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NW-1)) state <= FIX;
        end
        FIX: begin
          out       <= zero ? '0 : {fin_r, fin_i};
          div_zero  <= zero;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div.sv
// Directed self-checking bench for complex_div (W=4) with hand-computed quotients.
module tb_complex_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in1, in2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        div_zero;

  int vecCount  = 0;
  int failCount = 0;

  complex_div #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, measure latency, optionally stall the consumer, then drain.
  task automatic applyStimulus(input string tag, input logic [7:0] x, input logic [7:0] y,
                               input logic [15:0] expOut, input logic expDz,
                               input bit readyEarly, input int hold);
    int lat;
    @(negedge clk);
    checkOutput({tag, ".in_ready_idle"}, in_ready, 1);
    in1 = x; in2 = y; in_valid = 1'b1; out_ready = readyEarly;
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = ~x; in2 = 8'h00;
    checkOutput({tag, ".in_ready_busy"}, in_ready, 0);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 40);
    checkOutput({tag, ".latency"}, lat, 11);
    checkOutput({tag, ".out"}, out, expOut);
    checkOutput({tag, ".div_zero"}, div_zero, expDz);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, ".hold_out"}, out, expOut);
      checkOutput({tag, ".hold_valid"}, out_valid, 1);
      checkOutput({tag, ".hold_dz"}, div_zero, expDz);
      checkOutput({tag, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, ".drain_valid"}, out_valid, 0);
    checkOutput({tag, ".drain_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [15:0] expSeven, expMixed;
    bit sawValid;
`ifdef CDIV_ROUND_EN
    expSeven = 16'h0400;
    expMixed = 16'hFF01;
`else
    expSeven = 16'h0300;
    expMixed = 16'h0001;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0;
    #12;
    checkOutput("reset.out", out, 0);
    checkOutput("reset.out_valid", out_valid, 0);
    checkOutput("reset.div_zero", div_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 checkOutput("reset.in_ready", in_ready, 1);

    applyStimulus("basic",  8'h11, 8'h01, 16'h01FF, 1'b0, 1'b1, 0);
    applyStimulus("seven",  8'h70, 8'h20, expSeven, 1'b0, 1'b0, 0);
    applyStimulus("mixed",  8'hFD, 8'hE2, expMixed, 1'b0, 1'b0, 0);
    applyStimulus("dzero",  8'h37, 8'h00, 16'h0000, 1'b1, 1'b0, 0);
    applyStimulus("stall",  8'h11, 8'h01, 16'h01FF, 1'b0, 1'b0, 5);

    // Abort an operation during its fourth divide cycle.
    @(negedge clk);
    in1 = 8'h70; in2 = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort.out", out, 0);
    checkOutput("abort.out_valid", out_valid, 0);
    checkOutput("abort.div_zero", div_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 checkOutput("abort.in_ready", in_ready, 1);
    sawValid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abort.no_valid", sawValid, 0);

    applyStimulus("after_abort", 8'h70, 8'h20, expSeven, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
